// File: rtl/candle_pkg.sv
// Shared types and wrap-around helpers for the parametrised candle array controller.
package candle_pkg;

  localparam int unsigned MaxCandles = 64;

  typedef enum logic [0:0] {
    StIdle,
    StSeek
  } ext_state_t;

  // One-position step with wrap-around; dir = 1 walks downwards.
  function automatic int unsigned wrap_step(int unsigned pos, logic dir, int unsigned n);
    if (dir) begin
      return (pos == 0) ? n - 1 : pos - 1;
    end
    return (pos >= n - 1) ? 0 : pos + 1;
  endfunction

  // Sum taken at full width before reducing, so jumps longer than a lap wrap correctly.
  function automatic int unsigned wrap_add(int unsigned pos, int unsigned delta, int unsigned n);
    return (pos + delta) % n;
  endfunction

endpackage

// File: rtl/candle_seeker.sv
// Extinguisher FSM: walks ext_pos one candle per cycle and requests a clear on the first lit one.
module candle_seeker
  import candle_pkg::*;
#(
  parameter int unsigned NumCandles = 8,
  localparam int unsigned PosW      = $clog2(NumCandles)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumCandles-1:0] candle_state_i,
  input  logic                  extinguish_i,
  input  logic                  sweep_dir_i,
  input  logic                  all_out_i,
  output logic                  clr_req_o,
  output logic [PosW-1:0]       clr_pos_o,
  output logic [PosW-1:0]       ext_pos_o,
  output logic                  ext_busy_o
);

  ext_state_t      state_q, state_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [PosW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    clr_req_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (extinguish_i && !all_out_i) begin
          state_d = StSeek;
          cnt_d   = '0;
        end
      end
      StSeek: begin
        if (candle_state_i[pos_q]) begin
          clr_req_o = 1'b1;
          state_d   = StIdle;
        end else if (cnt_q == PosW'(NumCandles - 1)) begin
          // A full lap without a hit: the target was lost to a race, give up.
          state_d = StIdle;
        end else begin
          pos_d = PosW'(wrap_step(32'(pos_q), sweep_dir_i, NumCandles));
          cnt_d = cnt_q + PosW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_pos_o  = pos_q;
  assign ext_pos_o  = pos_q;
  assign ext_busy_o = (state_q == StSeek);

endmodule

// File: rtl/candle_array_ctrl.sv
// Candle register with igniter jump pointer, extinguisher seeker, set/clear arbitration and status.
module candle_array_ctrl
  import candle_pkg::*;
#(
  parameter int unsigned NUM_CANDLES = 8,
  parameter int unsigned DELTA_W     = 4,
  localparam int unsigned POS_W      = $clog2(NUM_CANDLES),
  localparam int unsigned CNT_W      = $clog2(NUM_CANDLES + 1)
) (
  input  logic                   sys_clk,
  input  logic                   clr_n,
  input  logic [DELTA_W-1:0]     delta,
  input  logic                   ignite,
  input  logic                   extinguish,
  input  logic                   sweep_dir,
  output logic [NUM_CANDLES-1:0] candle_state,
  output logic [POS_W-1:0]       ign_pos,
  output logic [POS_W-1:0]       ext_pos,
  output logic                   ext_busy,
  output logic [CNT_W-1:0]       lit_count,
  output logic                   all_lit,
  output logic                   all_out,
  output logic                   collision
);

  logic [NUM_CANDLES-1:0] candle_q, candle_d;
  logic [POS_W-1:0]       ign_pos_q, ign_pos_d;
  logic                   collision_q, collision_d;
  logic [POS_W-1:0]       ign_tgt;
  logic                   clr_req;
  logic [POS_W-1:0]       clr_pos;
  logic [CNT_W-1:0]       lit_cnt;

  candle_seeker #(
    .NumCandles(NUM_CANDLES)
  ) u_seeker (
    .clk_i         (sys_clk),
    .rst_ni        (clr_n),
    .candle_state_i(candle_q),
    .extinguish_i  (extinguish),
    .sweep_dir_i   (sweep_dir),
    .all_out_i     (all_out),
    .clr_req_o     (clr_req),
    .clr_pos_o     (clr_pos),
    .ext_pos_o     (ext_pos),
    .ext_busy_o    (ext_busy)
  );

  assign ign_tgt = POS_W'(wrap_add(32'(ign_pos_q), 32'(delta), NUM_CANDLES));

  // Set is applied after clear so a same-candle race leaves the candle lit.
  always_comb begin
    candle_d    = candle_q;
    ign_pos_d   = ign_pos_q;
    collision_d = 1'b0;
    if (clr_req) begin
      candle_d[clr_pos] = 1'b0;
    end
    if (ignite) begin
      ign_pos_d         = ign_tgt;
      candle_d[ign_tgt] = 1'b1;
      collision_d       = clr_req && (ign_tgt == clr_pos);
    end
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      candle_q    <= '0;
      ign_pos_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      candle_q    <= candle_d;
      ign_pos_q   <= ign_pos_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    lit_cnt = '0;
    for (int i = 0; i < NUM_CANDLES; i++) begin
      lit_cnt = lit_cnt + CNT_W'(candle_q[i]);
    end
  end

  assign candle_state = candle_q;
  assign ign_pos      = ign_pos_q;
  assign collision    = collision_q;
  assign lit_count    = lit_cnt;
  assign all_lit      = &candle_q;
  assign all_out      = ~|candle_q;

endmodule

// File: tb/tb_candle_array_ctrl.sv
// Directed bench for candle_array_ctrl at 8 and 6 candles with hand-computed expectations.
module tb_candle_array_ctrl;

  logic sys_clk = 1'b0;
  logic clr_n   = 1'b0;

  always #5 sys_clk = ~sys_clk;

  // 8-candle instance
  logic [3:0] delta8      = '0;
  logic       ignite8     = 1'b0;
  logic       ext8        = 1'b0;
  logic       dir8        = 1'b0;
  logic [7:0] cs8;
  logic [2:0] ign8, epos8;
  logic       busy8, alit8, aout8, coll8;
  logic [3:0] cnt8;

  // 6-candle instance
  logic [3:0] delta6      = '0;
  logic       ignite6     = 1'b0;
  logic       ext6        = 1'b0;
  logic       dir6        = 1'b0;
  logic [5:0] cs6;
  logic [2:0] ign6, epos6;
  logic       busy6, alit6, aout6, coll6;
  logic [2:0] cnt6;

  candle_array_ctrl #(
    .NUM_CANDLES(8),
    .DELTA_W    (4)
  ) dut8 (
    .sys_clk     (sys_clk),
    .clr_n       (clr_n),
    .delta       (delta8),
    .ignite      (ignite8),
    .extinguish  (ext8),
    .sweep_dir   (dir8),
    .candle_state(cs8),
    .ign_pos     (ign8),
    .ext_pos     (epos8),
    .ext_busy    (busy8),
    .lit_count   (cnt8),
    .all_lit     (alit8),
    .all_out     (aout8),
    .collision   (coll8)
  );

  candle_array_ctrl #(
    .NUM_CANDLES(6),
    .DELTA_W    (4)
  ) dut6 (
    .sys_clk     (sys_clk),
    .clr_n       (clr_n),
    .delta       (delta6),
    .ignite      (ignite6),
    .extinguish  (ext6),
    .sweep_dir   (dir6),
    .candle_state(cs6),
    .ign_pos     (ign6),
    .ext_pos     (epos6),
    .ext_busy    (busy6),
    .lit_count   (cnt6),
    .all_lit     (alit6),
    .all_out     (aout6),
    .collision   (coll6)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ignite pulse on dut8; returns at the negedge after the capturing edge.
  task automatic fire8(input logic [3:0] d);
    @(negedge sys_clk);
    delta8  = d;
    ignite8 = 1'b1;
    @(negedge sys_clk);
    ignite8 = 1'b0;
  endtask

  task automatic fire6(input logic [3:0] d);
    @(negedge sys_clk);
    delta6  = d;
    ignite6 = 1'b1;
    @(negedge sys_clk);
    ignite6 = 1'b0;
  endtask

  task automatic reset_all();
    @(negedge sys_clk);
    clr_n = 1'b0;
    @(negedge sys_clk);
    clr_n = 1'b1;
  endtask

  task automatic light_5a();
    logic [2:0] exp_pos [4];
    exp_pos = '{3'd3, 3'd6, 3'd1, 3'd4};
    for (int i = 0; i < 4; i++) begin
      fire8(4'd3);
      check_eq($sformatf("ign_pos[%0d]", i), 64'(ign8), 64'(exp_pos[i]));
    end
    check_eq("state_5a", 64'(cs8), 64'h5a);
    check_eq("lit_cnt_4", 64'(cnt8), 64'd4);
    check_eq("all_lit_0", 64'(alit8), 64'd0);
  endtask

  initial begin
    // Reset values while clr_n is held low from time zero
    #2;
    check_eq("rst_state", 64'(cs8), 64'h0);
    check_eq("rst_allout", 64'(aout8), 64'd1);
    @(negedge sys_clk);
    clr_n = 1'b1;

    light_5a();

    // Start a seek then drop reset mid-cycle, checking before the next rising edge
    @(negedge sys_clk);
    ext8 = 1'b1;
    @(negedge sys_clk);
    ext8 = 1'b0;
    check_eq("seek_busy", 64'(busy8), 64'd1);
    #2;
    clr_n = 1'b0;
    #1;
    check_eq("async_state", 64'(cs8), 64'h0);
    check_eq("async_ign", 64'(ign8), 64'd0);
    check_eq("async_ext", 64'(epos8), 64'd0);
    check_eq("async_busy", 64'(busy8), 64'd0);
    check_eq("async_cnt", 64'(cnt8), 64'd0);
    check_eq("async_flags", {62'd0, alit8, aout8}, 64'b01);
    check_eq("async_coll", 64'(coll8), 64'd0);
    @(negedge sys_clk);
    clr_n = 1'b1;

    // Ascending seek from 0 over 0x5A: miss at 0, hit at 1
    light_5a();
    @(negedge sys_clk);
    dir8 = 1'b0;
    ext8 = 1'b1;
    @(negedge sys_clk);
    ext8 = 1'b0;
    check_eq("asc_busy1", 64'(busy8), 64'd1);
    @(negedge sys_clk);
    check_eq("asc_busy2", 64'(busy8), 64'd1);
    check_eq("asc_pos2", 64'(epos8), 64'd1);
    @(negedge sys_clk);
    check_eq("asc_busy_done", 64'(busy8), 64'd0);
    check_eq("asc_state", 64'(cs8), 64'h58);
    check_eq("asc_ext", 64'(epos8), 64'd1);

    // Descending seek over 0x40 from 0: visits 0, 7, 6
    reset_all();
    fire8(4'd6);
    check_eq("dsc_setup", 64'(cs8), 64'h40);
    @(negedge sys_clk);
    dir8 = 1'b1;
    ext8 = 1'b1;
    @(negedge sys_clk);
    ext8 = 1'b0;
    check_eq("dsc_pos0", 64'(epos8), 64'd0);
    @(negedge sys_clk);
    check_eq("dsc_pos7", 64'(epos8), 64'd7);
    @(negedge sys_clk);
    check_eq("dsc_pos6", 64'(epos8), 64'd6);
    check_eq("dsc_busy3", 64'(busy8), 64'd1);
    @(negedge sys_clk);
    check_eq("dsc_done", 64'(busy8), 64'd0);
    check_eq("dsc_allout", 64'(aout8), 64'd1);
    check_eq("dsc_ext", 64'(epos8), 64'd6);

    // Collision: ign_pos 6 + 4 -> 2; seek 6,7,0,1,2 while igniting 2 (delta 8) on the hit edge
    fire8(4'd4);
    check_eq("col_setup", 64'(cs8), 64'h04);
    @(negedge sys_clk);
    dir8 = 1'b0;
    ext8 = 1'b1;
    @(negedge sys_clk);
    ext8 = 1'b0;
    repeat (4) @(negedge sys_clk);
    check_eq("col_pos", 64'(epos8), 64'd2);
    ignite8 = 1'b1;
    delta8  = 4'd8;
    @(negedge sys_clk);
    ignite8 = 1'b0;
    check_eq("col_state", 64'(cs8), 64'h04);
    check_eq("col_pulse", 64'(coll8), 64'd1);
    check_eq("col_idle", 64'(busy8), 64'd0);
    check_eq("col_ign", 64'(ign8), 64'd2);
    @(negedge sys_clk);
    check_eq("col_clear", 64'(coll8), 64'd0);

    // Six candles
    reset_all();
    @(negedge sys_clk);
    ext6 = 1'b1;
    @(negedge sys_clk);
    ext6 = 1'b0;
    check_eq("n6_nobusy1", 64'(busy6), 64'd0);
    @(negedge sys_clk);
    check_eq("n6_nobusy2", 64'(busy6), 64'd0);
    fire6(4'd4);
    check_eq("n6_pos4", 64'(ign6), 64'd4);
    fire6(4'd13);
    check_eq("n6_pos5", 64'(ign6), 64'd5);
    check_eq("n6_state30", 64'(cs6), 64'h30);
    fire6(4'd1);
    check_eq("n6_wrap0", 64'(ign6), 64'd0);
    fire6(4'd1);
    fire6(4'd1);
    fire6(4'd1);
    check_eq("n6_full", 64'(cs6), 64'h3f);
    check_eq("n6_all_lit", 64'(alit6), 64'd1);
    check_eq("n6_cnt6", 64'(cnt6), 64'd6);
    fire6(4'd0);
    check_eq("n6_relight_pos", 64'(ign6), 64'd3);
    check_eq("n6_relight_cnt", 64'(cnt6), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
